// File: rtl/cp0_mmu_timer_if.sv
// Bundle between the decode/commit stage and the CP0 register file: MTC0/MFC0 ports,
// exception/ERET/TLBP commit strobes and the status outputs the pipeline consumes.
interface cp0_mmu_timer_if #(
    parameter int TLB_ENTRIES = 16
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);

    logic [5:0]       hint;
    logic [7:0]       raddr;
    logic [31:0]      rdata;
    logic             wen;
    logic [7:0]       waddr;
    logic [31:0]      wdata;
    logic             exp_en;
    logic             exp_badvaddr_en;
    logic [31:0]      exp_badvaddr;
    logic             exp_bd;
    logic [4:0]       exp_code;
    logic [31:0]      exp_epc;
    logic             eret;
    logic             tlbp_en;
    logic             tlbp_hit;
    logic [IDX_W-1:0] tlbp_index;
    logic [31:0]      epc_address;
    logic             allow_interrupt;
    logic [7:0]       interrupt_flag;
    logic [IDX_W-1:0] random_index;
    logic             timer_int;

    modport master (
        output hint, raddr, wen, waddr, wdata,
        output exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
        output eret, tlbp_en, tlbp_hit, tlbp_index,
        input  rdata, epc_address, allow_interrupt, interrupt_flag, random_index, timer_int
    );

    modport slave (
        input  hint, raddr, wen, waddr, wdata,
        input  exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
        input  eret, tlbp_en, tlbp_hit, tlbp_index,
        output rdata, epc_address, allow_interrupt, interrupt_flag, random_index, timer_int
    );
endinterface

// File: rtl/cp0_mmu_timer.sv
// Coprocessor-0 register file for the Sirius MIPS core: exception state, TLB-support
// registers, Random/Wired pair, prescaled Count and Compare timer interrupt.
module cp0_mmu_timer #(
    parameter int TLB_ENTRIES = 16,
    parameter int COUNT_DIV   = 2,
    parameter int TIMER_EN    = 1
) (
    input logic            clk,
    input logic            rst,
    cp0_mmu_timer_if.slave bus
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    localparam int PS_W  = 5;
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(COUNT_DIV - 1);

    localparam logic [7:0] ADDR_INDEX    = 8'h00;
    localparam logic [7:0] ADDR_RANDOM   = 8'h08;
    localparam logic [7:0] ADDR_ENTRYLO0 = 8'h10;
    localparam logic [7:0] ADDR_ENTRYLO1 = 8'h18;
    localparam logic [7:0] ADDR_PAGEMASK = 8'h28;
    localparam logic [7:0] ADDR_WIRED    = 8'h30;
    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_ENTRYHI  = 8'h50;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] ENTRYHI_MASK = 32'hFFFF_E0FF;
    localparam logic [31:0] ENTRYLO_MASK = 32'h3FFF_FFFF;
    localparam logic [31:0] PGMASK_MASK  = 32'h1FFF_E000;

    logic [31:0]      status_q, status_d;
    logic             bd_q, bd_d;
    logic             ti_q, ti_d;
    logic [5:0]       ip_q, ip_d;
    logic [1:0]       sw_q, sw_d;
    logic [4:0]       exc_q, exc_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q, count_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [31:0]      compare_q, compare_d;
    logic [31:0]      entryhi_q, entryhi_d;
    logic [31:0]      entrylo0_q, entrylo0_d;
    logic [31:0]      entrylo1_q, entrylo1_d;
    logic [31:0]      pagemask_q, pagemask_d;
    logic             probe_q, probe_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] wired_q, wired_d;
    logic [IDX_W-1:0] random_q, random_d;

    logic wr_index, wr_entrylo0, wr_entrylo1, wr_pagemask, wr_wired;
    logic wr_count, wr_entryhi, wr_compare, wr_status, wr_cause, wr_epc;
    logic tick, timer_hit;
    logic [31:0] cause_rd;

    assign wr_index    = bus.wen && (bus.waddr == ADDR_INDEX);
    assign wr_entrylo0 = bus.wen && (bus.waddr == ADDR_ENTRYLO0);
    assign wr_entrylo1 = bus.wen && (bus.waddr == ADDR_ENTRYLO1);
    assign wr_pagemask = bus.wen && (bus.waddr == ADDR_PAGEMASK);
    assign wr_wired    = bus.wen && (bus.waddr == ADDR_WIRED);
    assign wr_count    = bus.wen && (bus.waddr == ADDR_COUNT);
    assign wr_entryhi  = bus.wen && (bus.waddr == ADDR_ENTRYHI);
    assign wr_compare  = bus.wen && (bus.waddr == ADDR_COMPARE);
    assign wr_status   = bus.wen && (bus.waddr == ADDR_STATUS);
    assign wr_cause    = bus.wen && (bus.waddr == ADDR_CAUSE);
    assign wr_epc      = bus.wen && (bus.waddr == ADDR_EPC);

    assign tick      = (ps_q == PS_LAST);
    assign timer_hit = !wr_count && tick && ((count_q + 32'd1) == compare_q);

    always_comb begin
        status_d   = status_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_d       = bus.hint;
        sw_d       = sw_q;
        exc_d      = exc_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        ps_d       = ps_q;
        compare_d  = compare_q;
        entryhi_d  = entryhi_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        pagemask_d = pagemask_q;
        probe_d    = probe_q;
        index_d    = index_q;
        wired_d    = wired_q;
        random_d   = random_q;

        if (wr_status) status_d = (status_q & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
        if (bus.exp_en)    status_d[1] = 1'b1;
        else if (bus.eret) status_d[1] = 1'b0;

        // A nested exception (EXL already set) keeps the original restart point and BD.
        if (bus.exp_en) begin
            exc_d = bus.exp_code;
            if (!status_q[1]) begin
                epc_d = bus.exp_epc;
                bd_d  = bus.exp_bd;
            end
            if (bus.exp_badvaddr_en) badvaddr_d = bus.exp_badvaddr;
        end else if (wr_epc) begin
            epc_d = bus.wdata;
        end
        if (wr_cause) sw_d = bus.wdata[9:8];

        if (wr_count) begin
            count_d = bus.wdata;
            ps_d    = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
            ps_d    = '0;
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
        if (wr_compare) compare_d = bus.wdata;

        if (TIMER_EN != 0) begin
            if (wr_compare)     ti_d = 1'b0;
            else if (timer_hit) ti_d = 1'b1;
        end else begin
            ti_d = 1'b0;
        end

        if (wr_entryhi)  entryhi_d  = bus.wdata & ENTRYHI_MASK;
        if (wr_entrylo0) entrylo0_d = bus.wdata & ENTRYLO_MASK;
        if (wr_entrylo1) entrylo1_d = bus.wdata & ENTRYLO_MASK;
        if (wr_pagemask) pagemask_d = bus.wdata & PGMASK_MASK;
        if (wr_wired)    wired_d    = bus.wdata[IDX_W-1:0];

        if (bus.tlbp_en) begin
            probe_d = ~bus.tlbp_hit;
            if (bus.tlbp_hit) index_d = bus.tlbp_index;
        end else if (wr_index) begin
            index_d = bus.wdata[IDX_W-1:0];
        end

        if (wr_wired || (random_q <= wired_q)) random_d = RAND_TOP;
        else                                   random_d = random_q - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            sw_q       <= '0;
            exc_q      <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            ps_q       <= '0;
            compare_q  <= '0;
            entryhi_q  <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            pagemask_q <= '0;
            probe_q    <= 1'b0;
            index_q    <= '0;
            wired_q    <= '0;
            random_q   <= RAND_TOP;
        end else begin
            status_q   <= status_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            sw_q       <= sw_d;
            exc_q      <= exc_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            ps_q       <= ps_d;
            compare_q  <= compare_d;
            entryhi_q  <= entryhi_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            pagemask_q <= pagemask_d;
            probe_q    <= probe_d;
            index_q    <= index_d;
            wired_q    <= wired_d;
            random_q   <= random_d;
        end
    end

    assign cause_rd = {bd_q, ti_q, 14'd0, ip_q[5] | ti_q, ip_q[4:0], sw_q, 1'b0, exc_q, 2'b00};

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.raddr)
            ADDR_INDEX:    bus.rdata = {probe_q, {(31 - IDX_W){1'b0}}, index_q};
            ADDR_RANDOM:   bus.rdata = {{(32 - IDX_W){1'b0}}, random_q};
            ADDR_ENTRYLO0: bus.rdata = entrylo0_q;
            ADDR_ENTRYLO1: bus.rdata = entrylo1_q;
            ADDR_PAGEMASK: bus.rdata = pagemask_q;
            ADDR_WIRED:    bus.rdata = {{(32 - IDX_W){1'b0}}, wired_q};
            ADDR_BADVADDR: bus.rdata = badvaddr_q;
            ADDR_COUNT:    bus.rdata = count_q;
            ADDR_ENTRYHI:  bus.rdata = entryhi_q;
            ADDR_COMPARE:  bus.rdata = compare_q;
            ADDR_STATUS:   bus.rdata = status_q;
            ADDR_CAUSE:    bus.rdata = cause_rd;
            ADDR_EPC:      bus.rdata = epc_q;
            default:       bus.rdata = 32'd0;
        endcase
    end

    assign bus.epc_address     = epc_q;
    assign bus.allow_interrupt = (status_q[2:0] == 3'b001);
    assign bus.interrupt_flag  = status_q[15:8] & cause_rd[15:8];
    assign bus.random_index    = random_q;
    assign bus.timer_int       = ti_q;
endmodule

// File: tb/tb_cp0_mmu_timer.sv
// Directed bench for cp0_mmu_timer (16-entry TLB, Count every 2 cycles, timer enabled):
// hand-computed expectations checked with immediate assertions.
module tb_cp0_mmu_timer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cp0_mmu_timer_if #(.TLB_ENTRIES(16)) bus ();

    cp0_mmu_timer #(.TLB_ENTRIES(16), .COUNT_DIV(2), .TIMER_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        bus.raddr = addr;
        #1;
        check_output(tag, bus.rdata, exp);
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
        bus.wen   = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        step();
        bus.wen   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.hint = '0; bus.raddr = '0; bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.exp_en = 1'b0; bus.exp_badvaddr_en = 1'b0; bus.exp_badvaddr = '0;
        bus.exp_bd = 1'b0; bus.exp_code = '0; bus.exp_epc = '0; bus.eret = 1'b0;
        bus.tlbp_en = 1'b0; bus.tlbp_hit = 1'b0; bus.tlbp_index = '0;
        step();

        $display("[TB] reset state, Count prescale and Random walk");
        do_reset();
        read_check("rst_status", 8'h60, 32'h0040_0000);
        read_check("rst_cause", 8'h68, 32'h0000_0000);
        read_check("rst_count", 8'h48, 32'h0000_0000);
        check_output("rst_random", 32'(bus.random_index), 32'd15);
        check_output("rst_allow", 32'(bus.allow_interrupt), 32'd0);
        check_output("rst_timer", 32'(bus.timer_int), 32'd0);
        for (int i = 1; i <= 17; i++) begin
            step();
            check_output("random_walk", 32'(bus.random_index), 32'((15 - i) & 15));
            if (i == 10) read_check("count_10cyc", 8'h48, 32'd5);
        end

        $display("[TB] Wired / Random interaction");
        do_reset();
        write_reg(8'h30, 32'd4);
        check_output("wired_force", 32'(bus.random_index), 32'd15);
        read_check("wired_rd", 8'h30, 32'd4);
        for (int j = 1; j <= 11; j++) step();
        check_output("random_floor", 32'(bus.random_index), 32'd4);
        step();
        check_output("random_rewrap", 32'(bus.random_index), 32'd15);
        step();
        check_output("random_after", 32'(bus.random_index), 32'd14);
        write_reg(8'h30, 32'd15);
        for (int j = 1; j <= 5; j++) step();
        check_output("random_pinned", 32'(bus.random_index), 32'd15);

        $display("[TB] Count write and Compare timer");
        do_reset();
        bus.wen = 1'b1; bus.waddr = 8'h48; bus.wdata = 32'h0000_1234;
        read_check("count_old", 8'h48, 32'd0);
        step();
        bus.wen = 1'b0;
        read_check("count_load", 8'h48, 32'h0000_1234);
        step();
        step();
        read_check("count_tick", 8'h48, 32'h0000_1235);
        write_reg(8'h58, 32'd3);
        write_reg(8'h48, 32'd0);
        for (int j = 1; j <= 5; j++) step();
        check_output("ti_early", 32'(bus.timer_int), 32'd0);
        read_check("count_2", 8'h48, 32'd2);
        step();
        check_output("ti_set", 32'(bus.timer_int), 32'd1);
        read_check("count_3", 8'h48, 32'd3);
        write_reg(8'h60, 32'h0000_8001);
        check_output("allow_int", 32'(bus.allow_interrupt), 32'd1);
        check_output("int_flag_ti", 32'(bus.interrupt_flag), 32'h80);
        read_check("cause_ti", 8'h68, 32'h4000_8000);
        write_reg(8'h58, 32'd100);
        check_output("ti_clear", 32'(bus.timer_int), 32'd0);
        check_output("int_flag_clr", 32'(bus.interrupt_flag), 32'h00);
        bus.hint = 6'b000001;
        step();
        read_check("cause_hint", 8'h68, 32'h0000_0400);
        write_reg(8'h60, 32'h0000_FF01);
        check_output("int_flag_hint", 32'(bus.interrupt_flag), 32'h04);
        bus.hint = 6'b000000;

        $display("[TB] exceptions and ERET");
        do_reset();
        bus.exp_en = 1'b1; bus.exp_code = 5'd4; bus.exp_epc = 32'h8000_0100;
        bus.exp_bd = 1'b1; bus.exp_badvaddr_en = 1'b1; bus.exp_badvaddr = 32'h0000_1234;
        step();
        bus.exp_en = 1'b0;
        read_check("exc_cause", 8'h68, 32'h8000_0010);
        check_output("exc_epc", bus.epc_address, 32'h8000_0100);
        read_check("exc_status", 8'h60, 32'h0040_0002);
        read_check("exc_badvaddr", 8'h40, 32'h0000_1234);
        bus.exp_en = 1'b1; bus.exp_code = 5'd2; bus.exp_epc = 32'h0000_0200;
        bus.exp_bd = 1'b0; bus.exp_badvaddr_en = 1'b0; bus.exp_badvaddr = 32'h0000_9999;
        step();
        bus.exp_en = 1'b0;
        check_output("nested_epc", bus.epc_address, 32'h8000_0100);
        read_check("nested_cause", 8'h68, 32'h8000_0008);
        read_check("nested_bva", 8'h40, 32'h0000_1234);
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        read_check("eret_status", 8'h60, 32'h0040_0000);
        bus.exp_en = 1'b1; bus.eret = 1'b1; bus.exp_code = 5'd1; bus.exp_epc = 32'h0000_0300;
        step();
        bus.exp_en = 1'b0; bus.eret = 1'b0;
        read_check("exp_over_eret", 8'h60, 32'h0040_0002);
        read_check("exp_eret_cause", 8'h68, 32'h0000_0004);
        check_output("exp_eret_epc", bus.epc_address, 32'h0000_0300);
        bus.eret = 1'b1;
        write_reg(8'h60, 32'h0000_FF03);
        bus.eret = 1'b0;
        read_check("eret_over_mtc0", 8'h60, 32'h0040_FF01);
        check_output("allow_after", 32'(bus.allow_interrupt), 32'd1);

        $display("[TB] write priority, TLBP and field masks");
        do_reset();
        bus.exp_en = 1'b1; bus.exp_epc = 32'h0000_5000; bus.exp_code = 5'd0; bus.exp_bd = 1'b0;
        write_reg(8'h70, 32'hAAAA_0000);
        bus.exp_en = 1'b0;
        check_output("exp_over_mtc0", bus.epc_address, 32'h0000_5000);
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        write_reg(8'h00, 32'd5);
        read_check("index_wr", 8'h00, 32'd5);
        bus.tlbp_en = 1'b1; bus.tlbp_hit = 1'b0; bus.tlbp_index = 4'd3;
        step();
        read_check("tlbp_miss", 8'h00, 32'h8000_0005);
        bus.tlbp_hit = 1'b1; bus.tlbp_index = 4'd7;
        step();
        bus.tlbp_en = 1'b0;
        read_check("tlbp_hit", 8'h00, 32'h0000_0007);
        write_reg(8'h00, 32'hFFFF_FFFF);
        read_check("index_mask", 8'h00, 32'h0000_000F);
        write_reg(8'h50, 32'hFFFF_FFFF);
        read_check("entryhi_mask", 8'h50, 32'hFFFF_E0FF);
        write_reg(8'h10, 32'hFFFF_FFFF);
        read_check("entrylo0_mask", 8'h10, 32'h3FFF_FFFF);
        write_reg(8'h18, 32'hFFFF_FFFF);
        read_check("entrylo1_mask", 8'h18, 32'h3FFF_FFFF);
        write_reg(8'h28, 32'hFFFF_FFFF);
        read_check("pagemask_mask", 8'h28, 32'h1FFF_E000);
        write_reg(8'h60, 32'hFFFF_FFFF);
        read_check("status_mask", 8'h60, 32'h0040_FF03);
        write_reg(8'h30, 32'hFFFF_FFFF);
        read_check("wired_mask", 8'h30, 32'h0000_000F);
        read_check("unimpl_rd4", 8'h20, 32'h0000_0000);
        read_check("unimpl_sel", 8'h61, 32'h0000_0000);

        rst = 1'b1;
        bus.exp_en = 1'b1; bus.exp_epc = 32'h0000_7777;
        write_reg(8'h60, 32'h0000_FF01);
        bus.exp_en = 1'b0;
        rst = 1'b0;
        read_check("rst_mid_status", 8'h60, 32'h0040_0000);
        check_output("rst_mid_epc", bus.epc_address, 32'h0000_0000);
        read_check("rst_mid_index", 8'h00, 32'h0000_0000);
        check_output("rst_mid_random", 32'(bus.random_index), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
